// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame receiver: FSM encoding, line levels, defaults.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;

  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out shift register: new bits enter at the MSB and move right,
// so after DATA_W shifts the first (LSB-first) bit sits in Q[0].
module sipo_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              Clkin,
  input  logic              Resetn,
  input  logic              shift_en,
  input  logic              Din,
  output logic [DATA_W-1:0] Q
);

  // Right shift with the serial bit entering at the top; cleared by reset
  always_ff @(posedge Clkin or negedge Resetn) begin
    if (!Resetn) begin
      Q <= '0;
    end else if (shift_en) begin
      Q <= {Din, Q[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, LSB-first data, optional parity, stop bit.
// Reports each accepted word with a registered one-cycle Valid pulse.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              Clkin,
  input  logic              Resetn,
  input  logic              Din,
  output logic [DATA_W-1:0] Dout,
  output logic              Valid,
  output logic              ParityErr,
  output logic              FrameErr,
  output logic              Busy,
  output logic [7:0]        FrameCount
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   bit_cnt;
  logic               last_bit;
  logic [DATA_W-1:0]  shift_q;
  logic               rx_par;
  logic               exp_par;
  logic               par_mismatch;

  logic               shift_en;
  logic               par_capture;
  logic               stop_ok;
  logic               stop_bad;

  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

  sipo_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift (
    .Clkin    (Clkin),
    .Resetn   (Resetn),
    .shift_en (shift_en),
    .Din      (Din),
    .Q        (shift_q)
  );

  // State register
  always_ff @(posedge Clkin or negedge Resetn) begin
    if (!Resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: walk start -> data -> (parity) -> stop, then back to idle
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (Din == START_LVL) next_state = ST_DATA;
      ST_DATA:   if (last_bit) next_state = PARITY_EN ? ST_PARITY : ST_STOP;
      ST_PARITY: next_state = ST_STOP;
      ST_STOP:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Per-state control strobes for the datapath
  always_comb begin
    shift_en    = 1'b0;
    par_capture = 1'b0;
    stop_ok     = 1'b0;
    stop_bad    = 1'b0;
    unique case (state)
      ST_DATA:   shift_en    = 1'b1;
      ST_PARITY: par_capture = 1'b1;
      ST_STOP: begin
        stop_ok  = (Din == STOP_LVL);
        stop_bad = (Din != STOP_LVL);
      end
      default: ;
    endcase
  end

  // Data bit counter: cleared while idle and after the last data bit
  always_ff @(posedge Clkin or negedge Resetn) begin
    if (!Resetn) begin
      bit_cnt <= '0;
    end else if (state == ST_IDLE) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  // Holds the received parity bit until the stop bit is judged
  always_ff @(posedge Clkin or negedge Resetn) begin
    if (!Resetn) begin
      rx_par <= 1'b0;
    end else if (par_capture) begin
      rx_par <= Din;
    end
  end

  assign exp_par      = (^shift_q) ^ PARITY_ODD;
  assign par_mismatch = PARITY_EN && (rx_par != exp_par);

  // Registered outputs: pulses last one cycle, Dout and FrameCount move only on accepted frames
  always_ff @(posedge Clkin or negedge Resetn) begin
    if (!Resetn) begin
      Dout       <= '0;
      Valid      <= 1'b0;
      ParityErr  <= 1'b0;
      FrameErr   <= 1'b0;
      FrameCount <= 8'd0;
    end else begin
      Valid     <= 1'b0;
      ParityErr <= 1'b0;
      FrameErr  <= 1'b0;
      if (stop_ok) begin
        Dout       <= shift_q;
        Valid      <= 1'b1;
        ParityErr  <= par_mismatch;
        FrameCount <= FrameCount + 8'd1;
      end
      if (stop_bad) begin
        FrameErr <= 1'b1;
      end
    end
  end

  assign Busy = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx with 8 data bits and even parity.
module tb_serial_frame_rx;

  logic       Clkin;
  logic       Resetn;
  logic       Din;
  logic [7:0] Dout;
  logic       Valid;
  logic       ParityErr;
  logic       FrameErr;
  logic       Busy;
  logic [7:0] FrameCount;

  typedef struct {
    logic       ferr;
    logic [7:0] data;
    logic       perr;
    logic [7:0] count;
  } exp_t;

  typedef struct {
    logic       ferr;
    logic       valid;
    logic [7:0] data;
    logic       perr;
    logic [7:0] count;
    int         cycle;
  } obs_t;

  exp_t       exp_q[$];
  obs_t       obs_q[$];
  int         tests_run;
  int         tests_failed;
  int         cyc;
  logic [7:0] exp_count;
  logic [7:0] exp_dout;

  serial_frame_rx #(
    .DATA_W     (8),
    .PARITY_EN  (1'b1),
    .PARITY_ODD (1'b0)
  ) dut (
    .Clkin      (Clkin),
    .Resetn     (Resetn),
    .Din        (Din),
    .Dout       (Dout),
    .Valid      (Valid),
    .ParityErr  (ParityErr),
    .FrameErr   (FrameErr),
    .Busy       (Busy),
    .FrameCount (FrameCount)
  );

  // 200 ns clock, first rising edge at 50 ns
  initial begin
    Clkin = 1'b0;
    #50;
    forever begin
      Clkin = 1'b1;
      #100;
      Clkin = 1'b0;
      #100;
    end
  end

  // Safety net so the run can never hang
  initial begin
    #(200 * 20000);
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one bit at a falling edge and record any output event seen one cycle later
  task automatic drive_bit(input logic b);
    obs_t o;
    Din = b;
    @(negedge Clkin);
    cyc++;
    if (Valid === 1'b1 || FrameErr === 1'b1) begin
      o.ferr  = FrameErr;
      o.valid = Valid;
      o.data  = Dout;
      o.perr  = ParityErr;
      o.count = FrameCount;
      o.cycle = cyc;
      obs_q.push_back(o);
    end
  endtask

  // Build and send one frame, pushing what the receiver should report
  task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop);
    exp_t e;
    logic p;
    p = ^data;
    if (bad_par) p = ~p;
    if (bad_stop) begin
      e.ferr  = 1'b1;
      e.data  = exp_dout;
      e.perr  = 1'b0;
      e.count = exp_count;
    end else begin
      exp_count = exp_count + 8'd1;
      exp_dout  = data;
      e.ferr    = 1'b0;
      e.data    = data;
      e.perr    = bad_par;
      e.count   = exp_count;
    end
    exp_q.push_back(e);
    drive_bit(1'b1);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(p);
    drive_bit(bad_stop ? 1'b1 : 1'b0);
  endtask

  task automatic test_reset;
    Resetn = 1'b0;
    Din    = 1'b0;
    #60;
    tests_run++;
    if (Dout !== 8'h00 || Valid !== 1'b0 || ParityErr !== 1'b0 || FrameErr !== 1'b0 ||
        Busy !== 1'b0 || FrameCount !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got Dout=%h V=%b PE=%b FE=%b B=%b FC=%0d, expected all 0",
               Dout, Valid, ParityErr, FrameErr, Busy, FrameCount);
    end
    #40;
    Resetn = 1'b1;
    @(negedge Clkin);
    for (int i = 0; i < 5; i++) begin
      drive_bit(1'b0);
      tests_run++;
      if (Busy !== 1'b0 || Valid !== 1'b0 || Dout !== 8'h00 || FrameCount !== 8'h00) begin
        tests_failed++;
        $display("[TB] FAIL idle_%0d: got B=%b V=%b Dout=%h FC=%0d, expected 0 0 00 0",
                 i, Busy, Valid, Dout, FrameCount);
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL idle_events: got %0d output events, expected 0", obs_q.size());
    end
    obs_q.delete();
    exp_count = 8'd0;
    exp_dout  = 8'd0;
  endtask

  task automatic test_good_frame;
    exp_t e;
    obs_t o;
    send_frame(8'hA5, 1'b0, 1'b0);
    tests_run++;
    if (obs_q.size() != 1) begin
      tests_failed++;
      $display("[TB] FAIL good_events: got %0d events, expected 1", obs_q.size());
    end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o.valid !== 1'b1 || o.data !== e.data || o.perr !== e.perr || o.count !== e.count) begin
        tests_failed++;
        $display("[TB] FAIL good_frame: got V=%b D=%h PE=%b FC=%0d, expected V=1 D=%h PE=%b FC=%0d",
                 o.valid, o.data, o.perr, o.count, e.data, e.perr, e.count);
      end
    end
    drive_bit(1'b0);
    tests_run++;
    if (Valid !== 1'b0 || ParityErr !== 1'b0 || Dout !== 8'hA5) begin
      tests_failed++;
      $display("[TB] FAIL good_pulse_end: got V=%b PE=%b D=%h, expected V=0 PE=0 D=a5",
               Valid, ParityErr, Dout);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_parity_error;
    exp_t e;
    obs_t o;
    send_frame(8'h01, 1'b1, 1'b0);
    tests_run++;
    if (obs_q.size() != 1) begin
      tests_failed++;
      $display("[TB] FAIL parity_events: got %0d events, expected 1", obs_q.size());
    end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o.valid !== 1'b1 || o.data !== e.data || o.perr !== e.perr || o.count !== e.count) begin
        tests_failed++;
        $display("[TB] FAIL parity_frame: got V=%b D=%h PE=%b FC=%0d, expected V=1 D=%h PE=%b FC=%0d",
                 o.valid, o.data, o.perr, o.count, e.data, e.perr, e.count);
      end
    end
    drive_bit(1'b0);
    tests_run++;
    if (ParityErr !== 1'b0 || Valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL parity_pulse_end: got V=%b PE=%b, expected 0 0", Valid, ParityErr);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_framing_error;
    exp_t e;
    obs_t o;
    send_frame(8'h3C, 1'b0, 1'b1);
    tests_run++;
    if (obs_q.size() != 1) begin
      tests_failed++;
      $display("[TB] FAIL frame_events: got %0d events, expected 1", obs_q.size());
    end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o.ferr !== 1'b1 || o.valid !== 1'b0 || o.data !== e.data || o.count !== e.count) begin
        tests_failed++;
        $display("[TB] FAIL framing_error: got FE=%b V=%b D=%h FC=%0d, expected FE=1 V=0 D=%h FC=%0d",
                 o.ferr, o.valid, o.data, o.count, e.data, e.count);
      end
    end
    drive_bit(1'b0);
    tests_run++;
    if (FrameErr !== 1'b0 || Busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL frame_pulse_end: got FE=%b B=%b, expected 0 0", FrameErr, Busy);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    exp_t e;
    obs_t o;
    int   first_cycle;
    send_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0);
    drive_bit(1'b0);
    tests_run++;
    if (obs_q.size() != 2) begin
      tests_failed++;
      $display("[TB] FAIL b2b_events: got %0d events, expected 2", obs_q.size());
    end
    first_cycle = -1;
    for (int k = 0; k < 2; k++) begin
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        tests_run++;
        if (o.valid !== 1'b1 || o.data !== e.data || o.perr !== e.perr || o.count !== e.count) begin
          tests_failed++;
          $display("[TB] FAIL b2b_frame_%0d: got V=%b D=%h PE=%b FC=%0d, expected V=1 D=%h PE=%b FC=%0d",
                   k, o.valid, o.data, o.perr, o.count, e.data, e.perr, e.count);
        end
        if (k == 0) begin
          first_cycle = o.cycle;
        end else if (first_cycle >= 0) begin
          tests_run++;
          if (o.cycle - first_cycle != 11) begin
            tests_failed++;
            $display("[TB] FAIL b2b_spacing: got %0d cycles, expected 11", o.cycle - first_cycle);
          end
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    exp_t e;
    obs_t o;
    drive_bit(1'b1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    tests_run++;
    if (Busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_busy: got B=%b, expected 1", Busy);
    end
    Din = 1'b0;
    #20;
    Resetn = 1'b0;
    #100;
    Resetn = 1'b1;
    @(negedge Clkin);
    exp_count = 8'd0;
    exp_dout  = 8'd0;
    tests_run++;
    if (Busy !== 1'b0 || Valid !== 1'b0 || Dout !== 8'h00 || FrameCount !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_state: got B=%b V=%b D=%h FC=%0d, expected 0 0 00 0",
               Busy, Valid, Dout, FrameCount);
    end
    obs_q.delete();
    exp_q.delete();
    send_frame(8'h12, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    tests_run++;
    if (obs_q.size() != 1) begin
      tests_failed++;
      $display("[TB] FAIL mid_events: got %0d events, expected 1", obs_q.size());
    end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o.valid !== 1'b1 || o.data !== e.data || o.perr !== e.perr || o.count !== e.count) begin
        tests_failed++;
        $display("[TB] FAIL mid_frame: got V=%b D=%h PE=%b FC=%0d, expected V=1 D=%h PE=%b FC=%0d",
                 o.valid, o.data, o.perr, o.count, e.data, e.perr, e.count);
      end
    end
    tests_run++;
    if (Dout !== exp_dout || FrameCount !== exp_count) begin
      tests_failed++;
      $display("[TB] FAIL mid_final: got D=%h FC=%0d, expected D=%h FC=%0d",
               Dout, FrameCount, exp_dout, exp_count);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Run every scenario in order, then report
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    exp_count    = 8'd0;
    exp_dout     = 8'd0;
    Din          = 1'b0;
    test_reset();
    test_good_frame();
    test_parity_error();
    test_framing_error();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
